// File: rtl/alien_missile_if.sv
// Game-side signal bundle for the enemy missile controller.
// Latency: none, wires only.
// Backpressure: none; launch requests not taken in ARMED are simply dropped.
interface alien_missile_if;
    logic       enable;
    logic       fire_valid;
    logic [9:0] fire_X;
    logic [9:0] fire_Y;
    logic [9:0] player_X_position;
    logic       cancel;
    logic [9:0] missile_X;
    logic [9:0] missile_Y;
    logic       missile_on_screen;
    logic       fire_ack;
    logic       player_hit;

    // Game/fleet side: drives requests, observes the missile.
    modport master (
        output enable, fire_valid, fire_X, fire_Y, player_X_position, cancel,
        input  missile_X, missile_Y, missile_on_screen, fire_ack, player_hit
    );

    // Missile controller side.
    modport slave (
        input  enable, fire_valid, fire_X, fire_Y, player_X_position, cancel,
        output missile_X, missile_Y, missile_on_screen, fire_ack, player_hit
    );
endinterface

// File: rtl/alien_missile.sv
// Enemy missile: cooldown -> armed -> flying, one step per frame, ends on floor/hit/cancel.
// Latency: launch appears one enabled edge after ARMED sees fire_valid; moves once per frame.
// Backpressure: fire_valid is only taken in ARMED (no queueing); enable=0 freezes all but the LFSR.
// Optional feature: define MISSILE_TRACK_EN to make the missile drift 1px/frame toward the player.
module alien_missile #(
    parameter int unsigned MISSILE_Y_STEP = 2,
    parameter int unsigned MISSILE_Y_MAX  = 479,
    parameter int unsigned MISSILE_H      = 4,
    parameter int unsigned PLAYER_Y       = 440,
    parameter int unsigned PLAYER_H       = 8,
    parameter int unsigned PLAYER_HALF_W  = 8,
    parameter int unsigned COOLDOWN_MIN   = 16
) (
    input  logic            frame_clk,
    input  logic            Reset,
    alien_missile_if.slave  bus
);
    typedef enum logic [1:0] {
        S_COOLDOWN = 2'd0,
        S_ARMED    = 2'd1,
        S_FLYING   = 2'd2
    } state_t;

    // Counter holds up to COOLDOWN_MIN + 31.
    localparam int CNT_W = 6;

    localparam logic [10:0] STEP_11   = 11'(MISSILE_Y_STEP);
    localparam logic [10:0] YMAX_11   = 11'(MISSILE_Y_MAX);
    localparam logic [10:0] MH_11     = 11'(MISSILE_H);
    localparam logic [10:0] PTOP_11   = 11'(PLAYER_Y);
    localparam logic [10:0] PBOT_11   = 11'(PLAYER_Y + PLAYER_H);
    localparam logic [10:0] HALFW_11  = 11'(PLAYER_HALF_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              on_q, on_d;
    logic              ack_q, ack_d;
    logic              hit_q, hit_d;
    logic [7:0]        lfsr_q, lfsr_d;

    logic [10:0]       mx_11, my_11, px_11, dx_11;
    logic              hit_now;
    logic              end_flight;

    // LFSR next value: x^8+x^6+x^5+x^4+1, shifted in at the bottom.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // Player hit test on the current position, all in 11 bits so nothing wraps.
    always_comb begin
        mx_11   = {1'b0, x_q};
        my_11   = {1'b0, y_q};
        px_11   = {1'b0, bus.player_X_position};
        dx_11   = (mx_11 >= px_11) ? (mx_11 - px_11) : (px_11 - mx_11);
        hit_now = ((my_11 + MH_11) >= PTOP_11) &&
                  (my_11 <= PBOT_11) &&
                  (dx_11 <= HALFW_11);
    end

    // Next-state and output logic for the missile flight FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        on_d       = on_q;
        ack_d      = 1'b0;
        hit_d      = 1'b0;
        end_flight = 1'b0;

        if (bus.enable) begin
            case (state_q)
                S_COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                S_ARMED: begin
                    if (bus.fire_valid) begin
                        x_d     = bus.fire_X;
                        y_d     = bus.fire_Y;
                        on_d    = 1'b1;
                        ack_d   = 1'b1;
                        state_d = S_FLYING;
                    end
                end
                S_FLYING: begin
                    if (bus.cancel) begin
                        end_flight = 1'b1;
                    end else if (hit_now) begin
                        hit_d      = 1'b1;
                        end_flight = 1'b1;
                    end else if ((my_11 + STEP_11) > YMAX_11) begin
                        end_flight = 1'b1;
                    end else begin
                        y_d = y_q + 10'(MISSILE_Y_STEP);
`ifdef MISSILE_TRACK_EN
                        if (x_q < bus.player_X_position) begin
                            x_d = x_q + 10'd1;
                        end else if (x_q > bus.player_X_position) begin
                            x_d = x_q - 10'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = S_COOLDOWN;
                end
            endcase
        end

        // Position holds its last value; only the visibility flag drops.
        if (end_flight) begin
            on_d    = 1'b0;
            cnt_d   = CNT_W'(COOLDOWN_MIN) + {1'b0, lfsr_q[4:0]};
            state_d = S_COOLDOWN;
        end
    end

    // State and output registers, cleared asynchronously by Reset.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_COOLDOWN;
            cnt_q   <= CNT_W'(COOLDOWN_MIN);
            x_q     <= '0;
            y_q     <= '0;
            on_q    <= 1'b0;
            ack_q   <= 1'b0;
            hit_q   <= 1'b0;
            lfsr_q  <= 8'hA5;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            on_q    <= on_d;
            ack_q   <= ack_d;
            hit_q   <= hit_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign bus.missile_X         = x_q;
    assign bus.missile_Y         = y_q;
    assign bus.missile_on_screen = on_q;
    assign bus.fire_ack          = ack_q;
    assign bus.player_hit        = hit_q;
endmodule

// File: tb/tb_alien_missile.sv
// Scoreboard bench for alien_missile: a frame-level reference model queues the expected
// outputs of every edge; a negedge monitor pops and compares. Directed scenarios follow
// the launch/floor/hit/cancel/freeze/reset/tracking cases, then randomized play.
module tb_alien_missile;
    logic clk;
    logic rst_n;

    alien_missile_if bus();

    alien_missile dut (
        .frame_clk (clk),
        .Reset     (rst_n),
        .bus       (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int x;
        int y;
        bit on;
        bit ack;
        bit hit;
    } exp_t;

    exp_t expq[$];
    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    // phase: 0 waiting out cooldown, 1 ready to launch, 2 missile in the air
    int m_phase, m_wait, m_x, m_y, m_lfsr;
    bit m_on, m_ack, m_hit;

    always @(posedge clk) begin
        exp_t e;
        int   dx;
        bit   finish_flight;
        if (!rst_n) begin
            m_phase = 0; m_wait = 16; m_x = 0; m_y = 0; m_lfsr = 8'hA5;
            m_on = 0; m_ack = 0; m_hit = 0;
        end else begin
            m_ack = 0;
            m_hit = 0;
            finish_flight = 0;
            if (bus.enable) begin
                if (m_phase == 0) begin
                    if (m_wait == 0) m_phase = 1;
                    else m_wait = m_wait - 1;
                end else if (m_phase == 1) begin
                    if (bus.fire_valid) begin
                        m_x = bus.fire_X; m_y = bus.fire_Y;
                        m_on = 1; m_ack = 1; m_phase = 2;
                    end
                end else begin
                    dx = m_x - int'(bus.player_X_position);
                    if (dx < 0) dx = -dx;
                    if (bus.cancel) finish_flight = 1;
                    else if (m_y + 4 >= 440 && m_y <= 448 && dx <= 8) begin
                        m_hit = 1; finish_flight = 1;
                    end else if (m_y + 2 > 479) finish_flight = 1;
                    else begin
                        m_y = m_y + 2;
`ifdef MISSILE_TRACK_EN
                        if (m_x < int'(bus.player_X_position)) m_x = m_x + 1;
                        else if (m_x > int'(bus.player_X_position)) m_x = m_x - 1;
`endif
                    end
                end
            end
            if (finish_flight) begin
                m_on = 0;
                m_wait = 16 + (m_lfsr % 32);
                m_phase = 0;
            end
            m_lfsr = ((m_lfsr << 1) & 8'hFF) |
                     (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
        end
        e.x = m_x; e.y = m_y; e.on = m_on; e.ack = m_ack; e.hit = m_hit;
        expq.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            total++;
            if (int'(bus.missile_X) != e.x || int'(bus.missile_Y) != e.y ||
                bus.missile_on_screen != e.on || bus.fire_ack != e.ack ||
                bus.player_hit != e.hit) begin
                bad++;
                $display("FAIL cycle t=%0t got x=%0d y=%0d on=%0b ack=%0b hit=%0b want x=%0d y=%0d on=%0b ack=%0b hit=%0b",
                         $time, bus.missile_X, bus.missile_Y, bus.missile_on_screen,
                         bus.fire_ack, bus.player_hit, e.x, e.y, e.on, e.ack, e.hit);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Returns at the negedge following the edge on which fire_ack was seen.
    task automatic wait_ack(input string name, input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.fire_ack) begin ok = 1; break; end
        end
        check({name, "_ack_seen"}, int'(ok), 1);
    endtask

    task automatic wait_end(input string name, input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!bus.missile_on_screen) begin ok = 1; break; end
        end
        check({name, "_end_seen"}, int'(ok), 1);
    endtask

    task automatic launch(input int fx, input int fy, input int px);
        #1;
        bus.fire_X = 10'(fx); bus.fire_Y = 10'(fy);
        bus.player_X_position = 10'(px);
        bus.fire_valid = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ack_edge;
        int y_hold, px;
        bit frozen_ok;

        rst_n = 1'b0;
        bus.enable = 1'b1; bus.fire_valid = 1'b1;
        bus.fire_X = 10'd200; bus.fire_Y = 10'd100;
        bus.player_X_position = 10'd500; bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_on", int'(bus.missile_on_screen), 0);
        check("reset_xy", int'(bus.missile_X) + int'(bus.missile_Y), 0);
        #1 rst_n = 1'b1;

        // Launch timing out of reset: fire_ack on edge 18.
        ack_edge = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.fire_ack) begin ack_edge = k; break; end
        end
        check("launch_ack_edge", ack_edge, 18);
        check("launch_x", int'(bus.missile_X), 200);
        check("launch_y", int'(bus.missile_Y), 100);
        #1 bus.fire_valid = 1'b0;
        @(negedge clk);
        check("first_move_y", int'(bus.missile_Y), 102);
        wait_end("first", 400);

        // Floor exit.
        launch(600, 470, 100);
        wait_ack("floor", 200);
        #1 bus.fire_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("floor_last_y", int'(bus.missile_Y), 478);
        check("floor_still_on", int'(bus.missile_on_screen), 1);
        @(negedge clk);
        check("floor_off", int'(bus.missile_on_screen), 0);
        check("floor_no_hit", int'(bus.player_hit), 0);

        // Player hit on the 4th flying edge.
        launch(100, 430, 104);
        wait_ack("hit", 200);
        #1 bus.fire_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("hit_pre_y", int'(bus.missile_Y), 436);
        @(negedge clk);
        check("hit_pulse", int'(bus.player_hit), 1);
        check("hit_off", int'(bus.missile_on_screen), 0);
        @(negedge clk);
        check("hit_one_cycle", int'(bus.player_hit), 0);

        // Cancel on the same edge beats the hit.
        launch(100, 430, 104);
        wait_ack("cancel", 200);
        #1 bus.fire_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 bus.cancel = 1'b1;
        @(negedge clk);
        check("cancel_no_hit", int'(bus.player_hit), 0);
        check("cancel_off", int'(bus.missile_on_screen), 0);
        #1 bus.cancel = 1'b0;

        // Freeze mid-flight, then asynchronous reset.
        launch(300, 100, 500);
        wait_ack("freeze", 200);
        #1 bus.fire_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 bus.enable = 1'b0;
        y_hold = int'(bus.missile_Y);
        frozen_ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (int'(bus.missile_Y) != y_hold || !bus.missile_on_screen ||
                bus.fire_ack || bus.player_hit) frozen_ok = 0;
        end
        check("freeze_hold", int'(frozen_ok), 1);
        #1 bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_on", int'(bus.missile_on_screen), 0);
        check("async_rst_xy", int'(bus.missile_X) + int'(bus.missile_Y), 0);
        check("async_rst_pulses", int'(bus.fire_ack) + int'(bus.player_hit), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Tracking toward the player.
        launch(100, 100, 110);
        wait_ack("track", 200);
        #1 bus.fire_valid = 1'b0;
        repeat (12) @(negedge clk);
`ifdef MISSILE_TRACK_EN
        check("track_x", int'(bus.missile_X), 110);
`else
        check("track_x", int'(bus.missile_X), 100);
`endif
        wait_end("track", 400);

        // Randomized play, scoreboard checks every edge.
        px = 320;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            #1;
            if (i % 64 == 0) px = int'($urandom_range(20, 620));
            bus.enable     = ($urandom % 8) != 0;
            bus.fire_valid = $urandom % 2;
            bus.fire_X     = 10'(px + int'($urandom_range(0, 24)) - 12);
            bus.fire_Y     = ($urandom % 4 == 0) ? 10'($urandom) : 10'($urandom_range(380, 479));
            bus.player_X_position = 10'(px);
            bus.cancel     = ($urandom % 40) == 0;
        end
        @(negedge clk);
        #1 bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("queue_drained", int'(expq.size() <= 1), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
